pwm_bank: RTL and testbench
===========================

# pwm_bank

Parametrised multi-channel PWM generator for LED dimming and general duty-cycle outputs. All channels share one programmable period counter, and each channel has its own duty compare. Configuration is double-buffered: a new period, mode and duty set is loaded through a valid/ready handshake and applied only at a period boundary, so outputs never glitch mid-period. Edge-aligned and center-aligned counting are both supported, plus a per-channel output polarity.

## Interface
Parameters:
- `CHANNELS`, 4: number of PWM outputs (1..32).
- `CNT_W`, 16: width of the counter, period and duty values.
- `ACTIVE_LOW_MASK`, 0: per-channel bit; 1 inverts that channel's output, making it active-low.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-low.
- `enable`  in  1  run the counter; when low, the counter is idle and outputs are inactive.
- `cfg_valid`  in  1  a configuration is offered this cycle.
- `cfg_ready`  out  1  staging register is free; a transfer occurs when `cfg_valid && cfg_ready`.
- `cfg_period`  in  CNT_W  top count P.
- `cfg_mode`  in  1  0 = edge-aligned, 1 = center-aligned.
- `cfg_duty`  in  CHANNELS*CNT_W  per-channel duty D[i]; channel i occupies bits [i*CNT_W +: CNT_W].
- `pwm_out`  out  CHANNELS  registered PWM outputs.
- `period_end`  out  1  registered one-cycle pulse marking each period boundary.
- `count`  out  CNT_W  current counter value, for debug.

## Operation
- Registers:
  - Active set: P, mode, D[].
  - Staging set, with a `pending` flag. `cfg_ready` = !pending.
  - Counter, and a direction bit `dir` (used in center mode).
- Handshake: on a transfer, the staging set captures the inputs and `pending` is set.
  - `cfg_valid` is ignored while `pending` is set.
  - Offered data does not need to be held stable while `cfg_ready` is low.
- Edge mode:
  - The counter runs 0,1,…,P, then wraps to 0. Period length is P+1 cycles.
  - Channel active when count < D[i]. D=0 gives always inactive; D ≥ P+1 gives always active.
- Center mode:
  - The counter runs 0↑P, then ↓ to 1, then back to 0. Period length is 2P cycles.
  - Channel active when count < D[i]. D=0 gives always inactive; D > P gives always active.
- P=0, either mode: the counter stays at 0, every cycle is a boundary, and a channel is active iff D ≥ 1.
- Boundary cycle: the cycle whose next count is 0 with `dir` up. This is count==P in edge mode, or the last descending count in center mode.
- Applying a pending config:
  - In a boundary cycle with `pending` set, the staging set is copied to the active set and `pending` is cleared.
  - The new values take effect from the following cycle, where count = 0 and `dir` is up.
  - A transfer accepted in a boundary cycle is applied at the next boundary, not the current one.
- Enable low:
  - Counter forced to 0 with `dir` up.
  - Every cycle counts as a boundary, so a pending config is applied on the next clock.
  - `pwm_out` is inactive and `period_end` is 0.
- Polarity: `pwm_out[i]` = active XOR `ACTIVE_LOW_MASK[i]`.
- Arithmetic: compares are unsigned on CNT_W bits, and the counter never exceeds P.

## Timing
- Reset (`reset`==0 at a clock edge):
  - count 0, `dir` up, active P=0, mode 0, D[]=0, staging cleared, `pending` 0.
  - `cfg_ready` 1 (combinational from `pending`), `period_end` 0, `pwm_out` = `ACTIVE_LOW_MASK`.
- Reset asserted mid-period or mid-handshake discards both the active and staging sets; no partial apply occurs.
- `pwm_out` and `period_end` are registered: each reflects the count and boundary state of the previous cycle (1-cycle latency).
- `cfg_ready` falls the cycle after a transfer. It rises the cycle after the apply.
- Enable rising: the first enabled cycle has count 0, and `pwm_out` reflects it one cycle later.

## Structure
- Package `pwm_pkg`:
  - `pwm_mode_t` enum (`PWM_EDGE`, `PWM_CENTER`).
  - Default `CNT_W` constant.
  - Packed struct `pwm_cfg_t` holding period and mode.
- Sub-module `pwm_channel`: one per channel, instantiated with a generate loop. Contains the duty compare, polarity XOR and output register, with inputs count, active D and enable.
- The top level holds the counter, direction logic, boundary detection and the handshake/shadow registers.

## Test plan
- Edge mode, P=9, D[0..3]={0,3,10,15}, one-cycle latency accounted for:
  - Per 10-cycle period, channels are high for 0, 3, 10 and 10 cycles.
  - `period_end` pulses every 10 cycles.
- Center mode, P=4, D[0]=2:
  - Count sequence 0,1,2,3,4,3,2,1 repeats (8 cycles).
  - Channel 0 is high on count 0,1 and again on the descending 1, i.e. 3 cycles per period.
- Double buffering, edge mode, P=9, D[0]=5:
  - At count 3, transfer D[0]=2: `cfg_ready` low until the boundary.
  - Duty of 5 holds through count 9; the next period shows duty 2.
  - A second `cfg_valid` during `pending` is ignored.
- Transfer accepted exactly at count==P: old config runs one more full period, and the new config appears the period after.
- `ACTIVE_LOW_MASK`=4'b0010, enable low:
  - `pwm_out`=4'b0010 constantly.
  - A config offered while disabled is applied within 2 cycles, and `cfg_ready` returns to 1.
- Reset mid-period with `pending` set, sampled the cycle after reset:
  - count 0, `pwm_out`=`ACTIVE_LOW_MASK`, `cfg_ready` 1.
  - With enable high, all channels stay inactive because D=0 and P=0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and constants for the pwm_bank PWM generator.
package pwm_pkg;

  localparam int unsigned PWM_CNT_W = 16;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_t;

  typedef struct packed {
    logic [PWM_CNT_W-1:0] period;
    pwm_mode_t            mode;
  } pwm_cfg_t;

endpackage

// File: rtl/pwm_bank_if.sv
// Configuration handshake for pwm_bank: period, mode and per-channel duty offered under valid/ready.
interface pwm_bank_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 16
);
  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [CNT_W-1:0]          cfg_period;
  logic                      cfg_mode;
  logic [CHANNELS*CNT_W-1:0] cfg_duty;

  modport master (output cfg_valid, output cfg_period, output cfg_mode, output cfg_duty,
                  input cfg_ready);
  modport slave  (input cfg_valid, input cfg_period, input cfg_mode, input cfg_duty,
                  output cfg_ready);
endinterface

// File: rtl/pwm_channel.sv
// One PWM output: duty compare against the shared count, polarity and output register.
module pwm_channel #(
  parameter int unsigned CNT_W      = 16,
  parameter logic        ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic [CNT_W-1:0] duty_i,
  output logic             pwm_o
);

  logic pwm_q;
  logic pwm_d;

  always_comb begin
    pwm_d = (enable_i && (count_i < duty_i)) ^ ACTIVE_LOW;
  end

  always_ff @(posedge clk) begin
    if (!reset) pwm_q <= ACTIVE_LOW;
    else        pwm_q <= pwm_d;
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM with a shared edge/center counter and double-buffered configuration
// that only takes effect at a period boundary.
module pwm_bank
  import pwm_pkg::*;
#(
  parameter int unsigned         CHANNELS        = 4,
  parameter int unsigned         CNT_W           = PWM_CNT_W,
  parameter logic [CHANNELS-1:0] ACTIVE_LOW_MASK = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  pwm_bank_if.slave           cfg,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_end,
  output logic [CNT_W-1:0]    count
);

  localparam int unsigned DUTY_W = CHANNELS * CNT_W;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dir_q, dir_d;
  logic              boundary;
  logic              period_end_q;

  logic [CNT_W-1:0]  act_period_q, stg_period_q;
  pwm_mode_t         act_mode_q, stg_mode_q;
  logic [DUTY_W-1:0] act_duty_q, stg_duty_q;
  logic              pending_q, pending_d;
  logic              transfer;
  logic              apply;

  // Next count/direction; a boundary is any cycle whose successor restarts at 0 going up.
  always_comb begin
    cnt_d = '0;
    dir_d = 1'b0;
    if (enable && (act_period_q != '0)) begin
      if (act_mode_q == PWM_EDGE) begin
        if (cnt_q < act_period_q) cnt_d = cnt_q + CNT_W'(1);
      end else if (!dir_q) begin
        if (cnt_q < act_period_q) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = act_period_q - CNT_W'(1);
          dir_d = (cnt_d != '0);
        end
      end else if (cnt_q > CNT_W'(1)) begin
        cnt_d = cnt_q - CNT_W'(1);
        dir_d = 1'b1;
      end
    end
    boundary = (cnt_d == '0) && !dir_d;
  end

  // Transfer and apply are mutually exclusive because they depend on opposite pending states.
  always_comb begin
    transfer  = cfg.cfg_valid && !pending_q;
    apply     = boundary && pending_q;
    pending_d = pending_q;
    if (apply)    pending_d = 1'b0;
    if (transfer) pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q        <= '0;
      dir_q        <= 1'b0;
      period_end_q <= 1'b0;
      pending_q    <= 1'b0;
      act_period_q <= '0;
      act_mode_q   <= PWM_EDGE;
      act_duty_q   <= '0;
      stg_period_q <= '0;
      stg_mode_q   <= PWM_EDGE;
      stg_duty_q   <= '0;
    end else begin
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      period_end_q <= enable && boundary;
      pending_q    <= pending_d;
      if (transfer) begin
        stg_period_q <= cfg.cfg_period;
        stg_mode_q   <= pwm_mode_t'(cfg.cfg_mode);
        stg_duty_q   <= cfg.cfg_duty;
      end
      if (apply) begin
        act_period_q <= stg_period_q;
        act_mode_q   <= stg_mode_q;
        act_duty_q   <= stg_duty_q;
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_channel #(
      .CNT_W      (CNT_W),
      .ACTIVE_LOW (ACTIVE_LOW_MASK[i])
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .enable_i (enable),
      .count_i  (cnt_q),
      .duty_i   (act_duty_q[i*CNT_W +: CNT_W]),
      .pwm_o    (pwm_out[i])
    );
  end

  assign cfg.cfg_ready = !pending_q;
  assign period_end    = period_end_q;
  assign count         = cnt_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Scoreboard bench for pwm_bank: a position-within-period model predicts every cycle's outputs.
module tb_pwm_bank;
  import pwm_pkg::*;

  localparam int unsigned CH = 4;
  localparam int unsigned CW = 16;
  localparam logic [CH-1:0] MASK = 4'b0010;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [CH-1:0] pwm_out;
  logic          period_end;
  logic [CW-1:0] count;

  pwm_bank_if #(.CHANNELS(CH), .CNT_W(CW)) cfg_if ();

  pwm_bank #(.CHANNELS(CH), .CNT_W(CW), .ACTIVE_LOW_MASK(MASK)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .cfg        (cfg_if),
    .pwm_out    (pwm_out),
    .period_end (period_end),
    .count      (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0] pwm;
    logic          pe;
    logic [CW-1:0] cnt;
    logic          rdy;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  pwm_cfg_t      m_act, m_stg;
  logic [CW-1:0] m_act_d[CH];
  logic [CW-1:0] m_stg_d[CH];
  logic          m_pending = 1'b0;
  int unsigned   m_pos = 0;
  logic [CW-1:0] m_count = '0;
  int            meas_hi[CH];
  int            meas_pe;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
  endtask

  // Period length in cycles for a configuration.
  function automatic int unsigned per_len(input pwm_cfg_t c);
    if (c.period == '0) return 1;
    if (c.mode == PWM_CENTER) return 2 * int'(c.period);
    return int'(c.period) + 1;
  endfunction

  // Count value shown at a given position inside the period (triangle in center mode).
  function automatic logic [CW-1:0] cnt_at(input pwm_cfg_t c, input int unsigned pos);
    int unsigned p = int'(c.period);
    if (c.mode == PWM_CENTER && pos > p) return CW'(2 * p - pos);
    return CW'(pos);
  endfunction

  // Reference model: advances one step per clock edge and queues the expected post-edge outputs.
  initial begin
    exp_t        e;
    logic [CW-1:0] c;
    logic        bnd, xfer, apl;
    m_act = '0;
    m_stg = '0;
    for (int i = 0; i < int'(CH); i++) begin
      m_act_d[i] = '0;
      m_stg_d[i] = '0;
    end
    forever begin
      @(posedge clk);
      if (!reset) begin
        m_act = '0;
        m_stg = '0;
        for (int i = 0; i < int'(CH); i++) begin
          m_act_d[i] = '0;
          m_stg_d[i] = '0;
        end
        m_pending = 1'b0;
        m_pos     = 0;
        e.pwm     = MASK;
        e.pe      = 1'b0;
      end else begin
        c   = cnt_at(m_act, m_pos);
        bnd = !enable || (m_pos == per_len(m_act) - 1);
        for (int i = 0; i < int'(CH); i++) e.pwm[i] = (enable && (c < m_act_d[i])) ^ MASK[i];
        e.pe = enable && bnd;
        xfer = cfg_if.cfg_valid && !m_pending;
        apl  = bnd && m_pending;
        if (apl) begin
          m_act = m_stg;
          for (int i = 0; i < int'(CH); i++) m_act_d[i] = m_stg_d[i];
          m_pending = 1'b0;
        end
        if (xfer) begin
          m_stg.period = cfg_if.cfg_period;
          m_stg.mode   = pwm_mode_t'(cfg_if.cfg_mode);
          for (int i = 0; i < int'(CH); i++) m_stg_d[i] = cfg_if.cfg_duty[i*CW +: CW];
          m_pending = 1'b1;
        end
        m_pos = bnd ? 0 : m_pos + 1;
      end
      m_count = cnt_at(m_act, m_pos);
      e.cnt   = m_count;
      e.rdy   = !m_pending;
      sb_q.push_back(e);
    end
  end

  // Monitor: compares every registered output against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("pwm_out",    32'(pwm_out),       32'(e.pwm));
        chk("period_end", 32'(period_end),    32'(e.pe));
        chk("count",      32'(count),         32'(e.cnt));
        chk("cfg_ready",  32'(cfg_if.cfg_ready), 32'(e.rdy));
      end
    end
  end

  task automatic offer(input logic [CW-1:0] p, input logic m, input logic [CH*CW-1:0] d);
    cfg_if.cfg_period = p;
    cfg_if.cfg_mode   = m;
    cfg_if.cfg_duty   = d;
    cfg_if.cfg_valid  = 1'b1;
    @(negedge clk);
    cfg_if.cfg_valid  = 1'b0;
  endtask

  task automatic wait_count(input logic [CW-1:0] v);
    for (int k = 0; k < 200; k++) begin
      if (m_count == v) return;
      @(negedge clk);
    end
    chk("wait_count_timeout", 32'(m_count), 32'(v));
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 200; k++) begin
      if (!m_pending) return;
      @(negedge clk);
    end
    chk("wait_ready_timeout", 32'(m_pending), 32'(0));
  endtask

  // Counts active (polarity-corrected) cycles per channel and boundary pulses over n samples.
  task automatic measure(input int n);
    for (int i = 0; i < int'(CH); i++) meas_hi[i] = 0;
    meas_pe = 0;
    repeat (n) begin
      @(negedge clk);
      for (int i = 0; i < int'(CH); i++) meas_hi[i] += int'(pwm_out[i] ^ MASK[i]);
      meas_pe += int'(period_end);
    end
  endtask

  initial begin
    reset            = 1'b0;
    enable           = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_period = '0;
    cfg_if.cfg_mode  = 1'b0;
    cfg_if.cfg_duty  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Disabled: config applies within two cycles, outputs stay at the polarity mask.
    offer(16'd9, 1'b0, {16'd15, 16'd10, 16'd3, 16'd0});
    @(negedge clk);
    chk("ready_after_disabled_apply", 32'(cfg_if.cfg_ready), 32'(1));
    chk("pwm_disabled", 32'(pwm_out), 32'(MASK));

    // Edge P=9: two periods.
    enable = 1'b1;
    measure(20);
    chk("edge_ch0", 32'(meas_hi[0]), 32'(0));
    chk("edge_ch1", 32'(meas_hi[1]), 32'(6));
    chk("edge_ch2", 32'(meas_hi[2]), 32'(20));
    chk("edge_ch3", 32'(meas_hi[3]), 32'(20));
    chk("edge_pe",  32'(meas_pe),    32'(2));

    // Center P=4: two 8-cycle periods.
    offer(16'd4, 1'b1, {16'd4, 16'd5, 16'd0, 16'd2});
    wait_ready();
    wait_count(16'd0);
    measure(16);
    chk("center_ch0", 32'(meas_hi[0]), 32'(6));
    chk("center_ch1", 32'(meas_hi[1]), 32'(0));
    chk("center_ch2", 32'(meas_hi[2]), 32'(16));
    chk("center_ch3", 32'(meas_hi[3]), 32'(14));
    chk("center_pe",  32'(meas_pe),    32'(2));

    // Double buffering: transfer at count 3, then a second offer while pending.
    offer(16'd9, 1'b0, {16'd3, 16'd2, 16'd1, 16'd5});
    wait_ready();
    wait_count(16'd3);
    offer(16'd9, 1'b0, {16'd3, 16'd2, 16'd1, 16'd2});
    chk("ready_low_pending", 32'(cfg_if.cfg_ready), 32'(0));
    cfg_if.cfg_duty  = {16'd3, 16'd2, 16'd1, 16'd7};
    cfg_if.cfg_valid = 1'b1;
    repeat (3) @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    wait_ready();
    wait_count(16'd0);
    measure(10);
    chk("dbuf_ch0", 32'(meas_hi[0]), 32'(2));

    // Transfer exactly at count==P: old duty runs one more full period.
    wait_count(16'd9);
    offer(16'd9, 1'b0, {16'd3, 16'd2, 16'd1, 16'd8});
    measure(10);
    chk("atP_old_ch0", 32'(meas_hi[0]), 32'(2));
    measure(10);
    chk("atP_new_ch0", 32'(meas_hi[0]), 32'(8));

    // Reset mid-period with a pending config.
    wait_count(16'd4);
    offer(16'd9, 1'b0, {16'd9, 16'd9, 16'd9, 16'd9});
    reset = 1'b0;
    @(negedge clk);
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_pwm",   32'(pwm_out), 32'(MASK));
    chk("rst_ready", 32'(cfg_if.cfg_ready), 32'(1));
    reset = 1'b1;
    measure(10);
    for (int i = 0; i < int'(CH); i++) chk("rst_inactive", 32'(meas_hi[i]), 32'(0));
    chk("rst_pe_every_cycle", 32'(meas_pe), 32'(10));

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      enable            = ($urandom_range(0, 9) != 0);
      reset             = ($urandom_range(0, 299) != 0);
      cfg_if.cfg_valid  = ($urandom_range(0, 3) == 0);
      cfg_if.cfg_period = CW'($urandom_range(0, 12));
      cfg_if.cfg_mode   = 1'($urandom_range(0, 1));
      for (int i = 0; i < int'(CH); i++) cfg_if.cfg_duty[i*CW +: CW] = CW'($urandom_range(0, 15));
      @(negedge clk);
    end
    cfg_if.cfg_valid = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
